// File: rtl/commit_marker_tracker.sv
`default_nettype none
// ============================================================================
// Module   : commit_marker_tracker
// Purpose  : Decodes retired phase-marker instructions from the ROB commit
//            lanes, tracks open phases, and queues timestamped events.
// Revision : 1.0 - initial release
// ============================================================================
module commit_marker_tracker #(
    parameter int COMMIT_WIDTH = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_W        = 32,
    parameter int LANE_W       = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [COMMIT_WIDTH-1:0]   commit_valid,
    input  logic [32*COMMIT_WIDTH-1:0] commit_inst,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [3:0]                evt_code,
    output logic [LANE_W-1:0]         evt_lane,
    output logic [CNT_W-1:0]          evt_cycle,
    output logic [CNT_W-1:0]          evt_dur,
    output logic                      evt_err,
    output logic [6:0]                phase_open,
    output logic                      err_sticky,
    output logic                      overflow_sticky,
    output logic                      sim_exit
);

    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_FW = c_PTR_W + 1;
    localparam int c_NPH    = 7;

    typedef struct packed {
        logic [3:0]        code;
        logic [LANE_W-1:0] lane;
        logic [CNT_W-1:0]  cycle;
        logic [CNT_W-1:0]  dur;
        logic              err;
    } evt_t;

    logic [CNT_W-1:0]    r_cnt;
    logic [6:0]          r_phase_open;
    logic [CNT_W-1:0]    r_start [c_NPH];
    logic                r_err_sticky;
    logic                r_ovf;
    logic                r_exit;
    evt_t                r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_FW-1:0] r_count;

    logic [6:0]          w_phase;
    logic [CNT_W-1:0]    w_start [c_NPH];
    logic                w_err_st;
    logic                w_ovf;
    logic                w_exit;
    logic                w_pop;
    logic [c_CNT_FW-1:0] w_free;
    logic [c_CNT_FW-1:0] w_npush;
    evt_t                w_ent [COMMIT_WIDTH];
    evt_t                w_head;

    // Lanes are walked in order so each lane sees the state left by the lower ones.
    always_comb begin
        logic [31:0] w_inst;
        logic [3:0]  w_code;
        logic [2:0]  w_ph;
        evt_t        w_ev;
        w_inst   = '0;
        w_code   = '0;
        w_ph     = '0;
        w_ev     = '0;
        w_phase  = r_phase_open;
        w_start  = r_start;
        w_err_st = r_err_sticky;
        w_ovf    = r_ovf;
        w_exit   = r_exit;
        w_pop    = (r_count != '0) && evt_ready;
        w_free   = c_CNT_FW'(FIFO_DEPTH) - r_count + c_CNT_FW'(w_pop);
        w_npush  = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            w_ent[k] = '0;
        end
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            w_inst = commit_inst[32*i +: 32];
            w_code = w_inst[23:20];
            w_ph   = w_code[3:1];
            if (commit_valid[i] && !w_exit && (w_inst[19:0] == 20'h02013) &&
                (w_inst[31:24] == 8'h00) && (w_code != 4'hF)) begin
                w_ev       = '0;
                w_ev.code  = w_code;
                w_ev.lane  = LANE_W'(i);
                w_ev.cycle = r_cnt;
                if (w_code == 4'd14) begin
                    w_exit = 1'b1;
                end else if (!w_code[0]) begin
                    if (w_phase[w_ph]) begin
                        w_ev.err = 1'b1;
                        w_err_st = 1'b1;
                    end else begin
                        w_phase[w_ph] = 1'b1;
                        w_start[w_ph] = r_cnt;
                    end
                end else begin
                    if (w_phase[w_ph]) begin
                        w_phase[w_ph] = 1'b0;
                        w_ev.dur      = r_cnt - w_start[w_ph];
                    end else begin
                        w_ev.err = 1'b1;
                        w_err_st = 1'b1;
                    end
                end
                // State above is updated even when the event record cannot be queued.
                if (w_npush < w_free) begin
                    w_ent[w_npush[LANE_W-1:0]] = w_ev;
                    w_npush = w_npush + c_CNT_FW'(1);
                end else begin
                    w_ovf = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt        <= '0;
            r_phase_open <= '0;
            r_err_sticky <= 1'b0;
            r_ovf        <= 1'b0;
            r_exit       <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            for (int p = 0; p < c_NPH; p++) begin
                r_start[p] <= '0;
            end
        end else begin
            r_cnt        <= r_cnt + CNT_W'(1);
            r_phase_open <= w_phase;
            r_start      <= w_start;
            r_err_sticky <= w_err_st;
            r_ovf        <= w_ovf;
            r_exit       <= w_exit;
            r_wr_ptr     <= r_wr_ptr + w_npush[c_PTR_W-1:0];
            r_rd_ptr     <= r_rd_ptr + c_PTR_W'(w_pop);
            r_count      <= r_count + w_npush - c_CNT_FW'(w_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (c_CNT_FW'(i) < w_npush) begin
                    r_mem[r_wr_ptr + c_PTR_W'(i)] <= w_ent[i];
                end
            end
        end
    end

    // Head fields are forced to zero when empty so stale entries never leak out.
    assign w_head          = r_mem[r_rd_ptr];
    assign evt_valid       = (r_count != '0);
    assign evt_code        = evt_valid ? w_head.code  : '0;
    assign evt_lane        = evt_valid ? w_head.lane  : '0;
    assign evt_cycle       = evt_valid ? w_head.cycle : '0;
    assign evt_dur         = evt_valid ? w_head.dur   : '0;
    assign evt_err         = evt_valid ? w_head.err   : 1'b0;
    assign phase_open      = r_phase_open;
    assign err_sticky      = r_err_sticky;
    assign overflow_sticky = r_ovf;
    assign sim_exit        = r_exit;

endmodule
`default_nettype wire

// File: tb/tb_commit_marker_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_commit_marker_tracker
// Purpose  : Directed self-checking bench for commit_marker_tracker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_commit_marker_tracker;

    localparam int CW     = 4;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 32;
    localparam int LANE_W = 2;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [CW-1:0]       commit_valid = '0;
    logic [32*CW-1:0]    commit_inst = '0;
    logic                evt_ready = 1'b1;
    logic                evt_valid;
    logic [3:0]          evt_code;
    logic [LANE_W-1:0]   evt_lane;
    logic [CNT_W-1:0]    evt_cycle;
    logic [CNT_W-1:0]    evt_dur;
    logic                evt_err;
    logic [6:0]          phase_open;
    logic                err_sticky;
    logic                overflow_sticky;
    logic                sim_exit;

    int errors = 0;
    int checks = 0;
    int cur    = 0;
    int cyc_s  = 0;
    int cyc_e  = 0;

    commit_marker_tracker #(
        .COMMIT_WIDTH(CW), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W), .LANE_W(LANE_W)
    ) dut (
        .clock(clock), .reset(reset),
        .commit_valid(commit_valid), .commit_inst(commit_inst),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_code(evt_code), .evt_lane(evt_lane), .evt_cycle(evt_cycle),
        .evt_dur(evt_dur), .evt_err(evt_err), .phase_open(phase_open),
        .err_sticky(err_sticky), .overflow_sticky(overflow_sticky),
        .sim_exit(sim_exit)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
        cur++;
    endtask

    task automatic clr();
        commit_valid = '0;
        commit_inst  = '0;
    endtask

    task automatic idle_to(int c);
        clr();
        while (cur < c) tick();
    endtask

    function automatic logic [31:0] mk(int code);
        logic [3:0] c4;
        c4 = 4'(code);
        return {8'h00, c4, 20'h02013};
    endfunction

    task automatic put(int lane, logic [31:0] inst);
        commit_valid[lane]         = 1'b1;
        commit_inst[32*lane +: 32] = inst;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        cur   = 0;
        chk("rst_valid", 64'(evt_valid), 64'd0);
        chk("rst_phase", 64'(phase_open), 64'd0);
        chk("rst_err", 64'(err_sticky), 64'd0);
        chk("rst_ovf", 64'(overflow_sticky), 64'd0);
        chk("rst_exit", 64'(sim_exit), 64'd0);
        chk("rst_cycle", 64'(evt_cycle), 64'd0);

        // Single START TEXE at cycle 5, visible one cycle later
        idle_to(5);
        chk("t1_pre_valid", 64'(evt_valid), 64'd0);
        put(0, 32'h00402013);
        tick(); clr();
        chk("t1_valid", 64'(evt_valid), 64'd1);
        chk("t1_code", 64'(evt_code), 64'd4);
        chk("t1_lane", 64'(evt_lane), 64'd0);
        chk("t1_cycle", 64'(evt_cycle), 64'd5);
        chk("t1_err", 64'(evt_err), 64'd0);
        chk("t1_phase", 64'(phase_open), 64'b0000100);

        // START/END VCTM in the same cycle on lanes 1 and 3
        idle_to(10);
        put(1, 32'h00002013);
        put(3, 32'h00102013);
        tick(); clr();
        chk("t2a_code", 64'(evt_code), 64'd0);
        chk("t2a_lane", 64'(evt_lane), 64'd1);
        chk("t2a_cycle", 64'(evt_cycle), 64'd10);
        tick();
        chk("t2b_valid", 64'(evt_valid), 64'd1);
        chk("t2b_code", 64'(evt_code), 64'd1);
        chk("t2b_lane", 64'(evt_lane), 64'd3);
        chk("t2b_dur", 64'(evt_dur), 64'd0);
        chk("t2b_err", 64'(evt_err), 64'd0);
        chk("t2b_cycle", 64'(evt_cycle), 64'd10);
        chk("t2_phase", 64'(phase_open), 64'b0000100);
        tick();
        chk("t2_empty", 64'(evt_valid), 64'd0);

        // Close TEXE opened at 5
        idle_to(15);
        put(0, mk(5));
        tick(); clr();
        chk("t3a_code", 64'(evt_code), 64'd5);
        chk("t3a_dur", 64'(evt_dur), 64'd10);
        chk("t3a_phase", 64'(phase_open), 64'd0);

        // TEXE 20..57, then an unmatched END at 60
        idle_to(20);
        put(0, mk(4));
        tick(); clr();
        chk("t3b_err", 64'(evt_err), 64'd0);
        idle_to(57);
        put(2, mk(5));
        tick(); clr();
        chk("t3c_code", 64'(evt_code), 64'd5);
        chk("t3c_lane", 64'(evt_lane), 64'd2);
        chk("t3c_dur", 64'(evt_dur), 64'd37);
        chk("t3c_err", 64'(evt_err), 64'd0);
        chk("t3c_sticky", 64'(err_sticky), 64'd0);
        idle_to(60);
        put(0, mk(5));
        tick(); clr();
        chk("t3d_err", 64'(evt_err), 64'd1);
        chk("t3d_dur", 64'(evt_dur), 64'd0);
        chk("t3d_sticky", 64'(err_sticky), 64'd1);
        tick();

        // Fill the FIFO with 8 LEAK markers while the consumer stalls
        evt_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            put(0, mk((k % 2 == 0) ? 6 : 7));
            tick(); clr();
        end
        chk("t4_full_code", 64'(evt_code), 64'd6);
        chk("t4_ovf_pre", 64'(overflow_sticky), 64'd0);
        cyc_s = cur;
        put(0, mk(8)); put(1, mk(10)); put(2, mk(12));
        tick(); clr();
        chk("t4_ovf", 64'(overflow_sticky), 64'd1);
        chk("t4_phase", 64'(phase_open), 64'b1110000);
        chk("t4_head_stable", 64'(evt_code), 64'd6);
        chk("t4_valid", 64'(evt_valid), 64'd1);

        // Full again, but a pop in the same cycle admits lane 0 only
        cyc_e = cur;
        evt_ready = 1'b1;
        put(0, mk(9)); put(1, mk(11)); put(2, mk(13));
        tick(); clr();
        chk("t4b_phase", 64'(phase_open), 64'd0);
        for (int j = 0; j < 7; j++) begin
            chk("t4b_drain", 64'(evt_code), (j % 2 == 0) ? 64'd7 : 64'd6);
            tick();
        end
        chk("t4b_new_code", 64'(evt_code), 64'd9);
        chk("t4b_new_lane", 64'(evt_lane), 64'd0);
        chk("t4b_new_dur", 64'(evt_dur), 64'(cyc_e - cyc_s));
        chk("t4b_new_err", 64'(evt_err), 64'd0);
        tick();
        chk("t4b_empty", 64'(evt_valid), 64'd0);

        // Queue 5 events, then reset for one cycle
        evt_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            put(0, mk((k % 2 == 0) ? 2 : 3));
            tick(); clr();
        end
        chk("t6_pre_valid", 64'(evt_valid), 64'd1);
        chk("t6_pre_phase", 64'(phase_open), 64'b0000010);
        reset = 1'b1;
        put(0, mk(0));
        tick(); clr();
        reset = 1'b0;
        cur   = 0;
        chk("t6_valid", 64'(evt_valid), 64'd0);
        chk("t6_phase", 64'(phase_open), 64'd0);
        chk("t6_err", 64'(err_sticky), 64'd0);
        chk("t6_ovf", 64'(overflow_sticky), 64'd0);
        chk("t6_exit", 64'(sim_exit), 64'd0);
        evt_ready = 1'b1;
        put(0, mk(0));
        tick(); clr();
        chk("t6_cnt0", 64'(evt_cycle), 64'd0);
        chk("t6_code", 64'(evt_code), 64'd0);
        chk("t6_phase1", 64'(phase_open), 64'b0000001);
        tick();

        // SIM_EXIT on lane 1 masks lane 2 and everything after
        idle_to(30);
        put(1, 32'h00e02013);
        put(2, 32'h00202013);
        tick(); clr();
        chk("t5_code", 64'(evt_code), 64'd14);
        chk("t5_lane", 64'(evt_lane), 64'd1);
        chk("t5_cycle", 64'(evt_cycle), 64'd30);
        chk("t5_exit", 64'(sim_exit), 64'd1);
        chk("t5_phase", 64'(phase_open), 64'b0000001);
        tick();
        chk("t5_only_one", 64'(evt_valid), 64'd0);
        idle_to(35);
        put(0, 32'h00202013);
        tick(); clr();
        tick();
        chk("t5_ignored", 64'(evt_valid), 64'd0);
        chk("t5_phase_kept", 64'(phase_open), 64'b0000001);
        chk("t5_no_ovf", 64'(overflow_sticky), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/commit_marker_tracker.md
Name: commit_marker_tracker

Overview:
- Sits directly upstream of the simulation sync monitor and taps the ROB commit (dequeue) ports.
- Recognises retired marker instructions, tracks which testcase phases are open, and timestamps each marker.
- Feeds the monitor's event handler one decoded event per cycle through a small FIFO.
- Testbench-only (non-synthesised) but cycle-accurate; one instance per core (DUT and variant).

Parameters:
- COMMIT_WIDTH, 4, number of commit lanes scanned per cycle
- FIFO_DEPTH, 8, event FIFO entries (power of two, >= COMMIT_WIDTH)
- CNT_W, 32, cycle counter and duration width
- LANE_W, max(1,$clog2(COMMIT_WIDTH)), lane index width

Ports:
- clock, input, 1, sole clock
- reset, input, 1, synchronous active-high reset
- commit_valid, input, COMMIT_WIDTH, per-lane retire valid
- commit_inst, input, 32*COMMIT_WIDTH, per-lane retired instruction; lane i is bits [32i+31:32i]
- evt_valid, output, 1, FIFO head valid
- evt_ready, input, 1, consumer accepts head
- evt_code, output, 4, marker code 0..14
- evt_lane, output, LANE_W, lane that committed the marker
- evt_cycle, output, CNT_W, cycle stamp at commit
- evt_dur, output, CNT_W, phase duration for a legal END, else 0
- evt_err, output, 1, this event violated phase nesting
- phase_open, output, 7, open-phase bitmask (bit = code>>1)
- err_sticky, output, 1, any nesting error since reset
- overflow_sticky, output, 1, any marker dropped since reset
- sim_exit, output, 1, SIM_EXIT seen (sticky)

Behaviour:
- Marker decode: lane valid, inst[19:0]==20'h02013, inst[31:24]==0, code=inst[23:20] <= 14 (code 15 is not a marker). Codes map to the phase markers slti x0,x0,k.
- Code semantics:
  - Even code 0..12: START of phase code>>1. Order is VCTM, DELAY, TEXE, LEAK, INIT, BIM, TRAIN.
  - Odd code 1..13: END of that phase.
  - Code 14: SIM_EXIT.
- Lane processing: in ascending lane order within a cycle. State updates from lane i are visible to lane i+1 in the same cycle.
- Cycle counter:
  - Free-running; 0 in the first cycle after reset deasserts; wraps modulo 2^CNT_W.
  - Every event from one cycle carries the same evt_cycle.
- START:
  - Phase closed: set bit, record start_cycle[phase]=counter, evt_err=0.
  - Phase already open: evt_err=1 and set err_sticky. start_cycle is not overwritten.
- END:
  - Phase open: clear bit, evt_dur=(counter-start_cycle) mod 2^CNT_W.
  - Phase not open: evt_err=1, err_sticky=1, evt_dur=0.
  - START then END of the same phase in one cycle is legal, with evt_dur=0.
- SIM_EXIT:
  - Enqueued like any other event and sets sim_exit.
  - Markers in higher lanes of the same cycle are ignored: no enqueue, no state change, no overflow.
  - While sim_exit=1, all markers are ignored.
- FIFO push:
  - Up to COMMIT_WIDTH pushes per cycle, in lane order.
  - Pop occurs when evt_valid&&evt_ready. A pop in the same cycle frees one slot usable by that cycle's pushes.
- FIFO full:
  - Markers beyond the free slots are dropped (highest lanes first) and overflow_sticky is set.
  - A dropped marker still updates phase_open and err_sticky; only its event record is lost.
- FIFO output:
  - evt_valid = FIFO non-empty; head fields are stable while evt_valid&&!evt_ready.
  - Push-to-visible latency: 1 cycle. A marker committed in cycle t is at the head in cycle t+1 if the FIFO was empty.
  - Pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an occupancy count of width $clog2(FIFO_DEPTH)+1.
- Reset:
  - All outputs 0; counter, FIFO, phase_open, start_cycles and sticky flags are cleared.
  - Reset asserted mid-stream discards queued events; commit inputs in reset cycles are ignored.

Test Plan:
- Lane0 commits 0x00402013 at cycle 5 (no others), evt_ready=1 -> cycle 6: evt_valid=1, code=4, lane=0, cycle=5, err=0; phase_open=7'b0000100.
- Cycle 10 lane1=0x00002013 and lane3=0x00102013 -> two events in order: (code 0, lane 1, dur 0), then (code 1, lane 3, dur 0); phase_open bit0 ends at 0.
- START TEXE at cycle 20, END TEXE (0x00502013) at cycle 57 -> END event dur=37, err=0; a second END at cycle 60 -> err=1, dur=0, err_sticky=1.
- evt_ready=0, 8 single markers queued, then 3 markers in one cycle -> all 3 dropped, overflow_sticky=1, count stays 8. Repeat with a concurrent pop -> lane0 accepted, lanes 1-2 dropped.
- Cycle 30 lane1=0x00e02013, lane2=0x00202013 -> only SIM_EXIT enqueued, sim_exit=1; later DELAY_START markers produce nothing.
- Reset asserted for one cycle with 5 queued events -> next cycle evt_valid=0, phase_open=0, stickies=0, counter restarts at 0.
